// File: rtl/lockin_modulator.sv
// Lock-in dither injector: adds amp-scaled LO to the servo word, saturating to 16-bit DAC range.
// Latency: 3 cycles LO_in/signal_in -> signal_out; active_out/timeout_out registered 1 cycle after the deciding sample.
// Backpressure: none, one sample accepted and produced every clock.
//
// Ports: clk_in/rst_in (async active-low); LO_in 24b signed LO sine; amp_in 16b signed
// dither amplitude; en_in modulation request; signal_in/signal_out 16b signed servo/DAC
// words; active_out gate state; timeout_out watchdog pulse; sat_out sticky clamp flag
// cleared by sat_clr_in. Optional macro LOCKIN_MOD_SAT_FLAG_EN enables sat_out;
// without it sat_out is tied low and sat_clr_in is ignored.
module lockin_modulator #(
    parameter int TIMEOUT_W = 20
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [23:0] LO_in,
    input  logic signed [15:0] amp_in,
    input  logic               en_in,
    input  logic signed [15:0] signal_in,
    output logic signed [15:0] signal_out,
    output logic               active_out,
    output logic               timeout_out,
    output logic               sat_out,
    input  logic               sat_clr_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

    state_t                 state_q, state_d;
    logic signed [15:0]     amp_act_q, amp_act_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d, wd_inc;
    logic signed [23:0]     lo_prev_q;
    logic                   active_q, timeout_q;
    logic                   zc, waiting, wd_expire, gate_d;

    // Next-state logic. The gate and amplitude chosen here apply to the sample
    // currently on LO_in, so a crossing sample is already modulated.
    always_comb begin
        zc        = lo_prev_q[23] & ~LO_in[23];
        state_d   = state_q;
        amp_act_d = amp_act_q;
        wd_d      = '0;
        wd_expire = 1'b0;
        wd_inc    = wd_q + 1'b1;
        waiting   = (state_q == ST_ARM) || (state_q == ST_DRAIN);

        case (state_q)
            ST_IDLE: begin
                if (en_in) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!en_in) begin
                    state_d = ST_IDLE;
                end else if (zc) begin
                    state_d   = ST_RUN;
                    amp_act_d = amp_in;
                end
            end
            ST_RUN: begin
                if (zc) amp_act_d = amp_in;
                if (!en_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en_in) begin
                    state_d = ST_RUN;
                end else if (zc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog only advances while waiting for a crossing with no state change.
        if (waiting && (state_d == state_q) && !zc) begin
            if (wd_inc == WD_MAX) begin
                wd_expire = 1'b1;
                wd_d      = '0;
                if (state_q == ST_DRAIN) state_d = ST_IDLE;
            end else begin
                wd_d = wd_inc;
            end
        end

        gate_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            amp_act_q <= '0;
            wd_q      <= '0;
            lo_prev_q <= '0;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            amp_act_q <= amp_act_d;
            wd_q      <= wd_d;
            lo_prev_q <= LO_in;
            active_q  <= gate_d;
            timeout_q <= wd_expire;
        end
    end

    // Datapath: stage 1 product, stage 2 shift+sum, stage 3 clamp.
    logic signed [39:0] prod_full, prod_d, prod_q;
    logic signed [15:0] sig_s1_q;
    logic signed [16:0] mod_s2;
    logic signed [17:0] sum_d, sum_q;
    logic               sat_hit;
    logic signed [15:0] sat_val, signal_q;

    always_comb begin
        prod_full = 40'(LO_in) * 40'(amp_act_d);
        prod_d    = gate_d ? prod_full : 40'sd0;
        // |prod| <= 2^38, so the shifted value always fits 17 signed bits.
        mod_s2    = 17'(prod_q >>> 23);
        sum_d     = 18'(sig_s1_q) + 18'(mod_s2);
        // In range exactly when the top three bits agree.
        sat_hit   = (sum_q[17:15] != 3'b000) && (sum_q[17:15] != 3'b111);
        if (sat_hit) begin
            sat_val = sum_q[17] ? 16'sh8000 : 16'sh7fff;
        end else begin
            sat_val = sum_q[15:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prod_q   <= '0;
            sig_s1_q <= '0;
            sum_q    <= '0;
            signal_q <= '0;
        end else begin
            prod_q   <= prod_d;
            sig_s1_q <= signal_in;
            sum_q    <= sum_d;
            signal_q <= sat_val;
        end
    end

    assign signal_out  = signal_q;
    assign active_out  = active_q;
    assign timeout_out = timeout_q;

`ifdef LOCKIN_MOD_SAT_FLAG_EN
    logic sat_q;

    // A clamp in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end else if (sat_clr_in) begin
            sat_q <= 1'b0;
        end
    end

    assign sat_out = sat_q;
`else
    logic unused_sat_clr;

    assign unused_sat_clr = sat_clr_in;
    assign sat_out        = 1'b0;
`endif

endmodule

// File: tb/tb_lockin_modulator.sv
// Self-checking bench for lockin_modulator: two instances (watchdog widths 20 and 4)
// share one stimulus stream and are compared every cycle against a sample-level model.
// Directed scenarios follow the lock-in use cases, then a randomized phase.
module tb_lockin_modulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [23:0] lo;
    logic signed [15:0] amp, sig;
    logic               en, sat_clr;
    logic signed [15:0] out_a, out_b;
    logic               act_a, act_b, to_a, to_b, sat_a, sat_b;

    lockin_modulator #(.TIMEOUT_W(20)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .LO_in(lo), .amp_in(amp), .en_in(en),
        .signal_in(sig), .signal_out(out_a), .active_out(act_a),
        .timeout_out(to_a), .sat_out(sat_a), .sat_clr_in(sat_clr)
    );

    lockin_modulator #(.TIMEOUT_W(4)) u_dut_wd (
        .clk_in(clk), .rst_in(rst_n), .LO_in(lo), .amp_in(amp), .en_in(en),
        .signal_in(sig), .signal_out(out_b), .active_out(act_b),
        .timeout_out(to_b), .sat_out(sat_b), .sat_clr_in(sat_clr)
    );

`ifdef LOCKIN_MOD_SAT_FLAG_EN
    localparam bit SAT_EXP = 1'b1;
`else
    localparam bit SAT_EXP = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

    typedef struct {
        int val;
        bit clamp;
    } res_t;

    int   wd_max[2] = '{(1 << 20) - 1, 15};
    int   m_st[2], m_amp[2], m_wd[2];
    bit   m_sat[2];
    int   m_prev;
    res_t pq0[$], pq1[$];
    int   exp_out[2];
    bit   exp_act[2], exp_to[2], exp_sat[2];

    task automatic model_reset();
        res_t z;
        z.val   = 0;
        z.clamp = 1'b0;
        m_prev  = 0;
        pq0     = {};
        pq1     = {};
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = M_IDLE;
            m_amp[k] = 0;
            m_wd[k]  = 0;
            m_sat[k] = 1'b0;
        end
        // Two samples already in flight through the reset pipeline.
        repeat (2) begin
            pq0.push_back(z);
            pq1.push_back(z);
        end
    endtask

    // Applies the current input sample; produces what the outputs hold after the edge.
    task automatic model_step();
        bit     zc, expire, gate;
        int     st, nst, cnt, modv, sumv;
        longint p;
        res_t   r;
        zc = (m_prev < 0) && (int'(lo) >= 0);
        for (int k = 0; k < 2; k++) begin
            st     = m_st[k];
            nst    = st;
            expire = 1'b0;
            case (st)
                M_IDLE:  if (en) nst = M_ARM;
                M_ARM: begin
                    if (!en) nst = M_IDLE;
                    else if (zc) begin
                        nst      = M_RUN;
                        m_amp[k] = int'(amp);
                    end
                end
                M_RUN: begin
                    if (zc) m_amp[k] = int'(amp);
                    if (!en) nst = M_DRAIN;
                end
                default: begin
                    if (en) nst = M_RUN;
                    else if (zc) nst = M_IDLE;
                end
            endcase
            // Cycles spent waiting in ARM/DRAIN since the last crossing or state change.
            cnt = 0;
            if ((st == M_ARM || st == M_DRAIN) && nst == st && !zc) begin
                cnt = m_wd[k] + 1;
                if (cnt == wd_max[k]) begin
                    expire = 1'b1;
                    cnt    = 0;
                    if (st == M_DRAIN) nst = M_IDLE;
                end
            end
            m_wd[k] = cnt;
            m_st[k] = nst;
            gate    = (nst == M_RUN) || (nst == M_DRAIN);
            modv    = 0;
            if (gate) begin
                p    = longint'(int'(lo)) * longint'(m_amp[k]);
                modv = int'(p >>> 23);
            end
            sumv    = int'(sig) + modv;
            r.clamp = (sumv > 32767) || (sumv < -32768);
            r.val   = (sumv > 32767) ? 32767 : ((sumv < -32768) ? -32768 : sumv);
            if (k == 0) begin
                pq0.push_back(r);
                r = pq0.pop_front();
            end else begin
                pq1.push_back(r);
                r = pq1.pop_front();
            end
            if (r.clamp) m_sat[k] = 1'b1;
            else if (sat_clr) m_sat[k] = 1'b0;
            exp_out[k] = r.val;
            exp_act[k] = gate;
            exp_to[k]  = expire;
            exp_sat[k] = SAT_EXP ? m_sat[k] : 1'b0;
        end
        m_prev = int'(lo);
    endtask

    // ---------------- stimulus helpers ----------------
    int ph;
    int peak_hi, peak_lo, to_cnt_b, act_rise_a;
    bit act_a_prev;

    task automatic peaks_reset();
        peak_hi = -100000;
        peak_lo = 100000;
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_val("out_a", out_a, exp_out[0]);
        check_val("act_a", act_a, exp_act[0]);
        check_val("tmo_a", to_a, exp_to[0]);
        check_val("sat_a", sat_a, exp_sat[0]);
        check_val("out_b", out_b, exp_out[1]);
        check_val("act_b", act_b, exp_act[1]);
        check_val("tmo_b", to_b, exp_to[1]);
        check_val("sat_b", sat_b, exp_sat[1]);
        if (int'(out_a) > peak_hi) peak_hi = int'(out_a);
        if (int'(out_a) < peak_lo) peak_lo = int'(out_a);
        if (to_b) to_cnt_b++;
        if (act_a && !act_a_prev) act_rise_a++;
        act_a_prev = act_a;
    endtask

    function automatic logic signed [23:0] sine(int p);
        real r;
        r = $sin(6.283185307179586 * real'(p) / 100.0) * 8388607.0;
        return 24'($rtoi(r));
    endfunction

    task automatic run_sine(int n);
        for (int i = 0; i < n; i++) begin
            lo = sine(ph % 100);
            ph++;
            step();
        end
    endtask

    task automatic run_const(logic signed [23:0] v, int n);
        lo = v;
        repeat (n) step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int tmp;
        bit neg;
        rst_n = 1'b0;
        lo = '0; amp = '0; sig = '0; en = 1'b0; sat_clr = 1'b0;
        act_a_prev = 1'b0; to_cnt_b = 0; act_rise_a = 0;
        @(negedge clk);
        check_val("rst_out", out_a, 0);
        check_val("rst_act", act_a, 0);
        check_val("rst_tmo", to_a, 0);
        check_val("rst_sat", sat_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Gating on: no output until the first rising crossing.
        en = 1'b1; amp = 16'sd1000; sig = '0; ph = 60;
        peaks_reset();
        run_sine(40);
        check_val("arm_quiet_hi", peak_hi, 0);
        check_val("arm_quiet_lo", peak_lo, 0);
        run_sine(10);
        peaks_reset();
        run_sine(90);
        check_val("run_pk_hi", peak_hi, 999);
        check_val("run_pk_lo", peak_lo, -1000);

        // Amplitude change mid-period takes effect only at the next crossing.
        run_sine(10);
        peaks_reset();
        run_sine(30);
        amp = 16'sd2000;
        run_sine(60);
        check_val("amp_hold_hi", peak_hi, 999);
        check_val("amp_hold_lo", peak_lo, -1000);
        run_sine(10);
        peaks_reset();
        run_sine(90);
        check_val("amp_new_hi", peak_hi, 1999);
        check_val("amp_new_lo", peak_lo, -2000);

        // Gating off mid-period: drains to the next crossing, then exact zero.
        run_sine(40);
        en = 1'b0;
        run_sine(70);
        peaks_reset();
        run_sine(90);
        check_val("off_hi", peak_hi, 0);
        check_val("off_lo", peak_lo, 0);

        // Saturation at LO positive full scale.
        en = 1'b1; amp = 16'sd2000; sig = 16'sd32000;
        run_const(-24'sd1, 1);
        run_const(24'sd8388607, 5);
        check_val("sat_val", out_a, 32767);
        sig = '0;
        run_const(24'sd8388607, 4);
        check_val("sat_hold", sat_a, SAT_EXP);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check_val("sat_clr", sat_a, 0);

        // Watchdog in DRAIN: LO stuck negative.
        sig = 16'sd1234; en = 1'b0; to_cnt_b = 0;
        run_const(-24'sd5, 30);
        check_val("wd_pulses", to_cnt_b, 1);
        check_val("wd_out", out_b, 1234);
        check_val("wd_long_act", act_a, 1);

        // Crossing and en drop together in ARM.
        run_const(24'sd5, 1);
        en = 1'b1;
        run_const(-24'sd5, 4);
        act_rise_a = 0;
        en = 1'b0;
        run_const(24'sd100, 6);
        check_val("simul_act", act_rise_a, 0);
        check_val("simul_out", out_a, 1234);

        // Reset in the middle of RUN.
        en = 1'b1; amp = 16'($urandom_range(500, 3000));
        sig = 16'(int'($urandom_range(0, 2000)) - 1000);
        ph = 60;
        run_sine(150 + int'($urandom_range(0, 40)));
        #3 rst_n = 1'b0;
        #1;
        check_val("rstm_out_a", out_a, 0);
        check_val("rstm_act_a", act_a, 0);
        check_val("rstm_tmo_a", to_a, 0);
        check_val("rstm_sat_a", sat_a, 0);
        check_val("rstm_out_b", out_b, 0);
        check_val("rstm_act_b", act_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ph = 10;
        run_sine(3);
        peaks_reset();
        run_sine(80);
        check_val("rstm_nomod_hi", peak_hi, int'(sig));
        check_val("rstm_nomod_lo", peak_lo, int'(sig));
        run_sine(20);

        // Randomized traffic.
        neg = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, (i < 750) ? 4 : 40) == 0) neg = ~neg;
            if (neg) tmp = -int'($urandom_range(1, 8388608));
            else     tmp = int'($urandom_range(0, 8388607));
            lo = 24'(tmp);
            if ($urandom_range(0, 9) == 0)  amp = 16'($urandom);
            if ($urandom_range(0, 29) == 0) en = ~en;
            sig     = 16'($urandom);
            sat_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lockin_modulator.md
# lockin_modulator

Injects the lock-in local oscillator as a dither onto the servo actuator path. It is the transmit end of the lock-in chain: it consumes the 24-bit LO sine that drives demodulation, scales it by a programmable amplitude, adds it to the servo output and saturates the sum to the 16-bit DAC word. Modulation is gated on and off, and amplitude changes are applied, only at rising zero crossings of the LO, so the actuator sees no steps. It sits between the servo/filter output and the DAC interface in the parent module.

## Interface
- `TIMEOUT_W`, 20: width of the zero-crossing watchdog counter.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `LO_in`  in  24  signed LO sine, full scale ±2^23.
- `amp_in`  in  16  signed modulation amplitude, in DAC LSB at LO full scale.
- `en_in`  in  1  modulation request (level).
- `signal_in`  in  16  signed servo output.
- `signal_out`  out  16  signed DAC word = sat16(signal_in + mod).
- `active_out`  out  1  high in RUN or DRAIN.
- `timeout_out`  out  1  one-cycle pulse on watchdog expiry.
- `sat_out`  out  1  sticky saturation flag (macro dependent).
- `sat_clr_in`  in  1  clears `sat_out`.

## Operation
- Zero-crossing detect `zc` is true when the registered previous LO is negative and the current `LO_in` is ≥ 0.
- The FSM has four states:
  - IDLE: gate off. On `en_in`=1, go to ARM.
  - ARM: gate off. On `zc`, latch `amp_in` into `amp_act` and go to RUN. On `en_in`=0, go to IDLE.
  - RUN: gate on. On each `zc`, relatch `amp_in`. On `en_in`=0, go to DRAIN.
  - DRAIN: gate on. On `zc`, go to IDLE with the gate off from that sample. On `en_in`=1, go to RUN.
- Watchdog: counts cycles since the last `zc` while in ARM or DRAIN. It clears on `zc` or on a state change.
  - On reaching 2^TIMEOUT_W−1, pulse `timeout_out`.
  - From DRAIN, the timeout forces IDLE.
  - In ARM, the timeout pulses and the counter restarts.
- Arithmetic:
  - `prod` = LO × `amp_act` (40-bit signed).
  - `mod` = `prod` >>> 23, arithmetic shift with truncation, kept as 17 bits signed.
  - When the gate is off, `mod` = 0.
  - `sum` = sext18(`signal_in`) + sext18(`mod`).
  - The result clamps to [−32768, 32767].
- `amp_in` changes outside `zc` have no effect until the next latch. A negative `amp_in` inverts the dither phase.
- Simultaneous `zc` and an `en_in` transition in the same cycle: the state transition is evaluated against the current state only. For example, in ARM with `en_in`=0 and `zc` both true, the FSM goes to IDLE.

## Timing
- Reset values: `signal_out`=0, `active_out`=0, `timeout_out`=0, `sat_out`=0, state IDLE, `amp_act`=0, previous LO=0, watchdog=0.
- Pipeline latency is 3 cycles from `LO_in`/`signal_in` to `signal_out`:
  - stage 1: register inputs, `prod`, gate.
  - stage 2: shift and sum.
  - stage 3: saturate and register.
- `signal_in` is delayed in step with LO.
- The gate and `amp_act` are sampled in the same stage-1 cycle as the `zc` sample, so the first modulated output sample is the crossing sample itself.
- `active_out` is registered from the state; it rises 1 cycle after the ARM→RUN `zc` cycle.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. After release, the block restarts in IDLE and rearms only via ARM.

## Configuration
- `LOCKIN_MOD_SAT_FLAG_EN`
  - Defined: `sat_out` sets on any cycle in which stage 3 clamps, and stays set until `sat_clr_in`=1. Set has priority over clear in the same cycle.
  - Undefined: `sat_out` is constant 0 and `sat_clr_in` is ignored. Clamping still occurs.

## Test plan
- Gating on/off:
  - Stimulus: LO sine of period 100 cycles, amplitude 2^23−1; `amp_in`=1000; `signal_in`=0; assert `en_in`.
  - Response: `signal_out` stays 0 until the first rising crossing + 3 cycles, then tracks ±999/1000.
  - Deassert `en_in` mid-cycle: output continues to the next rising crossing, then returns exactly to 0.
- Amplitude change: change `amp_in` from 1000 to 2000 mid-period.
  - Response: peak stays ~1000 until the next `zc`, then becomes ~2000; no discontinuity at the change cycle.
- Saturation:
  - Stimulus: `signal_in`=32000, `amp_in`=2000, LO at +full scale.
  - Response: `signal_out`=32767. With the macro defined, `sat_out` is 1 until `sat_clr_in` is pulsed. With the macro undefined, `sat_out` stays 0.
- Watchdog:
  - Stimulus: LO held constant at −5; `en_in`=1, then 0 after RUN is entered via a single crossing; use `TIMEOUT_W`=4.
  - Response: in DRAIN, `timeout_out` pulses once after 15 cycles, the FSM goes to IDLE, and `signal_out` returns to `signal_in`.
- Simultaneous events: in ARM, drop `en_in` on the same cycle as `zc`.
  - Response: the FSM goes to IDLE, `active_out` never rises, and `signal_out` stays equal to delayed `signal_in`.
- Reset mid-RUN: assert `rst_in`=0 at an arbitrary cycle.
  - Response: all outputs are 0 immediately; after release with `en_in`=1, modulation resumes only after a fresh rising crossing.
